// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory controller.
// Optional post-reset clear is selected with DMEM_CLEAR_EN.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dmem_state_e;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 6;
  localparam int DMEM_DEPTH  = 64;

  function automatic int dmem_nbytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Post-reset clear sequencer: walks every word writing zero,
// then raises ready and parks in IDLE. Built under DMEM_CLEAR_EN.
module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              ready_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          if (ptr_q == LAST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // No clear write on a reset edge: contents only change via the sweep.
  assign clr_we_o   = rst_ni & (state_q == ST_CLEAR);
  assign clr_addr_o = ptr_q;
  assign ready_o    = ready_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with byte enables, registered read,
// range check and optional clear sequencer (DMEM_CLEAR_EN).
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [DATA_W/8-1:0]    byte_en,
  input  logic [ADDR_W-1:0]      mem_address,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   rd_valid,
  output logic                   ready,
  output logic                   addr_err
);

  localparam int NB = dmem_nbytes(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef DMEM_CLEAR_EN
  dmem_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk_i      (clk),
    .rst_ni     (rst),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );
`else
  assign ready    = 1'b1;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic in_range;
  logic acc_wr;
  logic acc_rd;

  assign in_range = {1'b0, mem_address} < DEPTH_W;
  assign acc_wr   = rst & ready & wr_en;
  assign acc_rd   = rst & ready & rd_en & ~wr_en;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (acc_wr && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem_q[mem_address][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = acc_rd;
    addr_err_d = (acc_wr | acc_rd) & ~in_range;
    if (acc_rd) begin
      data_out_d = in_range ? mem_q[mem_address] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised single-port data memory for the 16-bit RISC core, the successor to the fixed 64×16 data memory. It adds configurable width and depth, per-byte write enables, a registered read with a valid strobe, out-of-range address detection and a post-reset clear sequencer. The clear sequencer zeroes every word, not only the low sixteen. The block sits between the core's load/store stage and the datapath register file.

## Interface
Parameters:
- DATA_W, 16: word width in bits; must be a multiple of 8.
- ADDR_W, 6: address width in bits.
- DEPTH, 64: number of words; must satisfy DEPTH ≤ 2^ADDR_W.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- byte_en  in  DATA_W/8  per-byte write mask; bit i gates data_in[8i+7:8i].
- mem_address  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse marking new data_out.
- ready  out  1  high when requests are accepted.
- addr_err  out  1  one-cycle pulse on an accepted request with mem_address ≥ DEPTH.

## Operation
- Reset (rst=0 at an edge) sets: data_out=0, rd_valid=0, addr_err=0, ready=0 (with the clear feature) or ready=1 (without it), clear pointer=0.
- FSM states:
  - CLEAR: writes 0 to word ptr and increments ptr; leaves for IDLE after writing word DEPTH-1.
  - IDLE: serves requests.
  - Reset always enters CLEAR, or IDLE when the clear feature is compiled out.
- Requests are accepted only when ready=1. Requests presented while ready=0 are silently dropped.
- Write: every byte with byte_en[i]=1 is updated; other bytes keep their contents. byte_en all-zero is a no-op write, and the read is still suppressed.
- Priority: wr_en has priority over rd_en. When both are high, the write is performed, no read occurs, rd_valid stays 0 and data_out holds.
- Read: data_out takes mem[mem_address]; rd_valid pulses.
- Out-of-range address (mem_address ≥ DEPTH):
  - A write is discarded.
  - A read sets data_out=0 and pulses rd_valid.
  - addr_err pulses in both cases.
- Memory contents are not affected by reset except through the clear sequence.

## Timing
- Read latency: 1 cycle. rd_en is sampled at edge N; data_out and rd_valid are valid after edge N. rd_valid falls at edge N+1 unless a new read is accepted there.
- Write latency: 1 cycle. A read of the same address at edge N+1 returns the new data.
- Back-to-back accesses every cycle are supported; there are no wait states in IDLE.
- Clear: takes exactly DEPTH cycles after reset is released. ready rises at the edge that writes word DEPTH-1, and the first request is accepted at the following edge.
- Reset asserted mid-clear restarts the clear at word 0.
- Reset asserted mid-read drops the read: rd_valid=0 and data_out=0 at the next edge.
- addr_err has the same timing as rd_valid and occurs for writes as well as reads.

## Configuration
- DMEM_CLEAR_EN defined: the CLEAR state and pointer are built. Memory is all-zero when ready first rises.
- DMEM_CLEAR_EN undefined:
  - No clear logic is built; ready is tied to 1 and the FSM is IDLE only.
  - Memory contents after reset are undefined, and the first request may be issued at the first edge after reset is released.

## Structure
- Package dmem_pkg holds:
  - the state enum (ST_CLEAR, ST_IDLE);
  - default constants DMEM_DATA_W=16, DMEM_ADDR_W=6, DMEM_DEPTH=64;
  - the byte-count helper function (DATA_W/8).
- One sub-module, dmem_clear_seq: holds the pointer, the FSM and ready generation, and drives the clear write port (address, zero data, write strobe). It is instantiated only under DMEM_CLEAR_EN.
- The array, byte-lane write logic, read register and range check stay in data_memory_ctrl.

## Test plan
- Reset then clear (DMEM_CLEAR_EN, DEPTH=64): ready=0 for 64 cycles, then 1. Reading addresses 0, 17 and 63 each returns 16'h0000 with rd_valid pulsing one cycle later.
- Byte-lane write: write 16'hABCD with byte_en=2'b11 to address 5, then 16'h12FF with byte_en=2'b01. Reading address 5 returns 16'hABFF.
- Simultaneous wr_en=rd_en=1 at address 9 with data 16'h5A5A: rd_valid stays 0 and data_out holds. A following read of address 9 returns 16'h5A5A.
- Range check with DEPTH=48, ADDR_W=6:
  - Writing 16'h1111 to address 50 pulses addr_err and leaves memory unchanged.
  - Reading address 50 returns 0 with rd_valid=1 and addr_err=1.
- Reset mid-clear: assert rst=0 at clear word 30. After release, ready stays 0 for a full 64 cycles.
- Request while ready=0: a write of 16'hBEEF to address 3 during clear is dropped. After ready rises, reading address 3 returns 16'h0000.
